mac_stim_seq: RTL and testbench
===============================

Name: mac_stim_seq

Overview:
- Synthesizable, parametrised stimulus sequencer for the floating-point MAC datapath.
- Emits a programmable number of operand triples (A, B, C) over a valid/ready handshake.
- Four selectable modes: directed table, raw LFSR random, normal-only random, IEEE special-value sweep.
- Replaces one-shot fixed-vector stimulus; usable in simulation benches and on-FPGA self-test.

Parameters:
- PARM_XLEN, 32, operand width; must equal 1 + PARM_EXP + PARM_MANT.
- PARM_EXP, 8, exponent field width.
- PARM_MANT, 23, mantissa field width.
- PARM_BIAS, 127, exponent bias.
- PARM_CNT_W, 16, width of vector count.
- PARM_SEED, 32'hACE12468, LFSR reset/start seed; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_i  in  1  start pulse; sampled only in IDLE
- mode_i  in  2  0 directed, 1 raw random, 2 normal random, 3 special; latched at start
- num_vec_i  in  PARM_CNT_W  vectors to emit; latched at start
- ready_i  in  1  consumer accepts the current vector
- A_o, B_o, C_o  out  PARM_XLEN  operands
- valid_o  out  1  operands valid
- vec_idx_o  out  PARM_CNT_W  index of the vector currently presented
- busy_o  out  1  high in LOAD/DRIVE
- done_o  out  1  one-cycle pulse after last accept

Behaviour:
- Reset (async, any state): IDLE; all outputs 0; LFSR = PARM_SEED; counter 0.
- FSM IDLE -> LOAD on start_i:
  - Latch mode_i and num_vec_i.
  - Reload LFSR with PARM_SEED, so every run is reproducible.
  - If num_vec_i == 0, go directly to DONE.
- LOAD (1 cycle): compute vector 0 into output registers; -> DRIVE with valid_o = 1.
- DRIVE, accept = valid_o & ready_i:
  - On accept with vec_idx_o < N-1: next vector is presented the following cycle; valid_o stays 1 (back-to-back, one vector per cycle).
  - On accept of vector N-1: valid_o -> 0; -> DONE.
  - While not accepted: A/B/C/vec_idx_o held stable.
- DONE (1 cycle): done_o = 1; busy_o = 0; -> IDLE.
- start_i outside IDLE is ignored. Reset mid-run aborts with no done_o.
- Latency: start_i at cycle t gives valid_o at t+2.
- Field helper F(s, e, m) = {s, e[PARM_EXP-1:0], m[PARM_MANT-1:0]}.
  - H = 1 << (PARM_MANT-1); EM = all-ones exponent.
- Mode 0, directed (index mod 4):
  - 0: A = F(0,BIAS,H), B = F(0,BIAS+1,0), C = F(0,BIAS+1,H); i.e. 1.5, 2.0, 3.0 for FP32.
  - 1: A = B = C = F(0,BIAS,0).
  - 2: A = F(1,BIAS,0), B = F(0,BIAS+1,0), C = F(0,BIAS+1,H).
  - 3: A = 0, B = F(0,EM,0), C = F(0,BIAS,0).
- Mode 1, raw random:
  - 32-bit Galois LFSR, mask 32'h80200003, shift right; advances once per accept.
  - A = low XLEN bits of state replicated; B, C same from state rotated left by 11 and 22.
- Mode 2, normal random: as mode 1, then per operand clamp the exponent field: 0 -> 1, EM -> EM-1.
- Mode 3, special sweep (index mod 6), same value on A, B and C:
  - +0, -0, +inf, -inf, qNaN F(0,EM,H), min denormal F(0,0,1).
- vec_idx_o wraps naturally at 2^PARM_CNT_W - 1; num_vec_i up to that value is supported.

Optional Feature:
- Macro MAC_STIM_CHECKSUM_EN.
- Defined:
  - Extra output port chksum_o [PARM_XLEN-1:0].
  - Cleared at start_i accept in IDLE.
  - XORed with (A_o ^ B_o ^ C_o) on every accept; held after DONE until the next start.
  - Reset value 0.
- Undefined: port absent; no checksum logic.

Test Plan:
- Reset during DRIVE at vector 3 of 10 -> valid_o, busy_o, A_o drop to 0 immediately (async); no done_o; new start gives a fresh run from PARM_SEED.
- Mode 0, N = 5, ready_i tied 1:
  - valid_o at t+2; A/B/C = 3FC00000/40000000/40400000, then 3F800000 x3, BF800000/40000000/40400000, 00000000/7F800000/3F800000, then 3FC00000/40000000/40400000.
  - done_o pulses one cycle after the 5th accept.
- Mode 0, N = 2, ready_i low for 4 cycles then high -> vector 0 held stable 4 cycles; vec_idx_o 0 then 1; done_o once.
- Mode 2, N = 1000, random ready_i:
  - Every exponent field is in 1..254.
  - Sequence matches the bench LFSR model; two runs are identical.
- Mode 3, N = 6 -> 00000000, 80000000, 7F800000, FF800000, 7FC00000, 00000001 on A, B and C.
- N = 0 -> valid_o never asserted; done_o pulses at t+1. start_i pulsed during DRIVE -> ignored, vector count unchanged.

Source files
------------

// File: rtl/mac_stim_seq_if.sv
// Operand bus between the MAC stimulus sequencer (master) and its consumer (slave).
// Handshake: a vector transfers on a rising clk edge where valid_o && ready_i; while valid_o is high and not accepted, the master holds A_o/B_o/C_o/vec_idx_o stable.
interface mac_stim_seq_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  A_o;
  logic [XLEN-1:0]  B_o;
  logic [XLEN-1:0]  C_o;
  logic             valid_o;
  logic             ready_i;
  logic [CNT_W-1:0] vec_idx_o;

  modport master (output A_o, B_o, C_o, valid_o, vec_idx_o, input ready_i);
  modport slave  (input A_o, B_o, C_o, valid_o, vec_idx_o, output ready_i);
endinterface

// File: rtl/mac_stim_seq.sv
// Stimulus sequencer for the FP MAC datapath: directed / LFSR / normal-only / special-value operand triples.
// Optional running XOR checksum of accepted operands when MAC_STIM_CHECKSUM_EN is defined.
module mac_stim_seq #(
  parameter int          PARM_XLEN  = 32,
  parameter int          PARM_EXP   = 8,
  parameter int          PARM_MANT  = 23,
  parameter int          PARM_BIAS  = 127,
  parameter int          PARM_CNT_W = 16,
  parameter logic [31:0] PARM_SEED  = 32'hACE12468
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            mode_i,
  input  logic [PARM_CNT_W-1:0] num_vec_i,
  mac_stim_seq_if.master        bus,
  output logic                  busy_o,
  output logic                  done_o,
`ifdef MAC_STIM_CHECKSUM_EN
  output logic [PARM_XLEN-1:0]  chksum_o,
`endif
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRIVE, S_DONE} state_t;

  localparam logic [PARM_MANT-1:0] L_H      = {1'b1, {(PARM_MANT-1){1'b0}}};
  localparam logic [PARM_MANT-1:0] L_M0     = '0;
  localparam logic [PARM_EXP-1:0]  L_EM     = '1;
  localparam logic [PARM_EXP-1:0]  L_E0     = '0;
  localparam logic [PARM_EXP-1:0]  L_BIAS   = PARM_EXP'(PARM_BIAS);
  localparam logic [PARM_EXP-1:0]  L_BIAS1  = PARM_EXP'(PARM_BIAS + 1);
  localparam logic [31:0]          L_MASK   = 32'h80200003;
  localparam int                   L_VW     = 3 * PARM_XLEN;

  state_t                 r_state, w_state_nx;
  logic [1:0]             r_mode;
  logic [PARM_CNT_W-1:0]  r_num;
  logic [PARM_CNT_W-1:0]  r_idx;
  logic [2:0]             r_mod6;
  logic [31:0]            r_lfsr;
  logic [PARM_XLEN-1:0]   r_a, r_b, r_c;
  logic                   r_valid;
  logic [PARM_XLEN-1:0]   r_chk;

  logic                   w_accept;
  logic                   w_last;
  logic [31:0]            w_lfsr_nx;
  logic [2:0]             w_mod6_nx;
  logic [1:0]             w_gen_idx2;
  logic [2:0]             w_gen_m6;
  logic [31:0]            w_gen_lfsr;
  logic [L_VW-1:0]        w_gen;

  function automatic logic [PARM_XLEN-1:0] fld(input logic s, input logic [PARM_EXP-1:0] e,
                                               input logic [PARM_MANT-1:0] m);
    return {s, e, m};
  endfunction

  // Replicate the 32-bit LFSR word across however wide an operand is.
  function automatic logic [PARM_XLEN-1:0] rep(input logic [31:0] s);
    logic [PARM_XLEN-1:0] v;
    for (int i = 0; i < PARM_XLEN; i++) v[i] = s[i % 32];
    return v;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] s, input int n);
    return (s << n) | (s >> (32 - n));
  endfunction

  function automatic logic [PARM_XLEN-1:0] clamp(input logic [PARM_XLEN-1:0] x);
    logic [PARM_XLEN-1:0] v;
    v = x;
    if (x[PARM_XLEN-2:PARM_MANT] == L_E0)      v[PARM_XLEN-2:PARM_MANT] = PARM_EXP'(1);
    else if (x[PARM_XLEN-2:PARM_MANT] == L_EM) v[PARM_XLEN-2:PARM_MANT] = L_EM - PARM_EXP'(1);
    return v;
  endfunction

  function automatic logic [L_VW-1:0] gen_vec(input logic [1:0] mode, input logic [1:0] idx2,
                                              input logic [2:0] m6, input logic [31:0] s);
    logic [PARM_XLEN-1:0] a, b, c, sp;
    a = rep(s);
    b = rep(rotl(s, 11));
    c = rep(rotl(s, 22));
    case (m6)
      3'd0:    sp = fld(1'b0, L_E0, L_M0);
      3'd1:    sp = fld(1'b1, L_E0, L_M0);
      3'd2:    sp = fld(1'b0, L_EM, L_M0);
      3'd3:    sp = fld(1'b1, L_EM, L_M0);
      3'd4:    sp = fld(1'b0, L_EM, L_H);
      default: sp = fld(1'b0, L_E0, PARM_MANT'(1));
    endcase
    case (mode)
      2'd0: begin
        case (idx2)
          2'd0:    return {fld(1'b0, L_BIAS, L_H), fld(1'b0, L_BIAS1, L_M0), fld(1'b0, L_BIAS1, L_H)};
          2'd1:    return {3{fld(1'b0, L_BIAS, L_M0)}};
          2'd2:    return {fld(1'b1, L_BIAS, L_M0), fld(1'b0, L_BIAS1, L_M0), fld(1'b0, L_BIAS1, L_H)};
          default: return {{PARM_XLEN{1'b0}}, fld(1'b0, L_EM, L_M0), fld(1'b0, L_BIAS, L_M0)};
        endcase
      end
      2'd1:    return {a, b, c};
      2'd2:    return {clamp(a), clamp(b), clamp(c)};
      default: return {3{sp}};
    endcase
  endfunction

  assign w_accept  = r_valid & bus.ready_i;
  assign w_last    = (r_idx == r_num - PARM_CNT_W'(1));
  assign w_lfsr_nx = (r_lfsr >> 1) ^ (r_lfsr[0] ? L_MASK : 32'd0);
  assign w_mod6_nx = (r_mod6 == 3'd5) ? 3'd0 : r_mod6 + 3'd1;

  // LOAD builds vector 0 from the freshly seeded LFSR; DRIVE builds the successor on accept.
  assign w_gen_idx2 = (r_state == S_LOAD) ? 2'd0 : r_idx[1:0] + 2'd1;
  assign w_gen_m6   = (r_state == S_LOAD) ? 3'd0 : w_mod6_nx;
  assign w_gen_lfsr = (r_state == S_LOAD) ? r_lfsr : w_lfsr_nx;
  assign w_gen      = gen_vec(r_mode, w_gen_idx2, w_gen_m6, w_gen_lfsr);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nx = (num_vec_i == '0) ? S_DONE : S_LOAD;
      S_LOAD:  w_state_nx = S_DRIVE;
      S_DRIVE: if (w_accept && w_last) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_num   <= '0;
      r_idx   <= '0;
      r_mod6  <= '0;
      r_lfsr  <= PARM_SEED;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_valid <= 1'b0;
      r_chk   <= '0;
    end else begin
      r_state <= w_state_nx;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mode <= mode_i;
            r_num  <= num_vec_i;
            r_lfsr <= PARM_SEED;
            r_chk  <= '0;
          end
        end
        S_LOAD: begin
          {r_a, r_b, r_c} <= w_gen;
          r_valid <= 1'b1;
          r_idx   <= '0;
          r_mod6  <= '0;
        end
        S_DRIVE: begin
          if (w_accept) begin
            r_chk  <= r_chk ^ r_a ^ r_b ^ r_c;
            r_lfsr <= w_lfsr_nx;
            if (w_last) begin
              r_valid <= 1'b0;
            end else begin
              {r_a, r_b, r_c} <= w_gen;
              r_idx  <= r_idx + PARM_CNT_W'(1);
              r_mod6 <= w_mod6_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.A_o       = r_a;
  assign bus.B_o       = r_b;
  assign bus.C_o       = r_c;
  assign bus.valid_o   = r_valid;
  assign bus.vec_idx_o = r_idx;
  assign busy_o        = (r_state == S_LOAD) || (r_state == S_DRIVE);
  assign done_o        = (r_state == S_DONE);
  assign dbg_state_o   = r_state;

`ifdef MAC_STIM_CHECKSUM_EN
  assign chksum_o = r_chk;
`else
  logic w_chk_unused;
  assign w_chk_unused = ^r_chk;
`endif

endmodule

// File: tb/tb_mac_stim_seq.sv
// Self-checking bench for mac_stim_seq: directed steps, random ready, spec-level reference model.
module tb_mac_stim_seq;
  localparam logic [31:0] SEED = 32'hACE12468;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [15:0] num_vec_i = 16'd0;
  logic        busy_o, done_o;
  logic [1:0]  dbg_state_o;
`ifdef MAC_STIM_CHECKSUM_EN
  logic [31:0] chksum_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [95:0] obs_q[$];
  logic [95:0] run1_q[$];

  mac_stim_seq_if #(.XLEN(32), .CNT_W(16)) bus ();

  mac_stim_seq dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .num_vec_i(num_vec_i),
    .bus(bus.master), .busy_o(busy_o), .done_o(done_o),
`ifdef MAC_STIM_CHECKSUM_EN
    .chksum_o(chksum_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model, expressed from the operand rules rather than the RTL structure
  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'd0);
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] s, input int n);
    return (s << n) | (s >> (32 - n));
  endfunction

  function automatic logic [31:0] clamp_exp(input logic [31:0] x);
    int e;
    e = int'((x >> 23) & 32'hFF);
    if (e == 0)   return (x & ~(32'hFF << 23)) | (32'd1 << 23);
    if (e == 255) return (x & ~(32'hFF << 23)) | (32'd254 << 23);
    return x;
  endfunction

  function automatic logic [95:0] model_vec(input int mode, input int idx, input logic [31:0] s);
    logic [31:0] dir_tab [4][3];
    logic [31:0] sp_tab [6];
    dir_tab = '{'{32'h3FC00000, 32'h40000000, 32'h40400000},
                '{32'h3F800000, 32'h3F800000, 32'h3F800000},
                '{32'hBF800000, 32'h40000000, 32'h40400000},
                '{32'h00000000, 32'h7F800000, 32'h3F800000}};
    sp_tab = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000001};
    case (mode)
      0:       return {dir_tab[idx % 4][0], dir_tab[idx % 4][1], dir_tab[idx % 4][2]};
      1:       return {s, rotl(s, 11), rotl(s, 22)};
      2:       return {clamp_exp(s), clamp_exp(rotl(s, 11)), clamp_exp(rotl(s, 22))};
      default: return {3{sp_tab[idx % 6]}};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver + scoreboard: one full run; rmode 0 = ready high, 1 = random, 2 = low for 4 valid cycles
  task automatic run_vec(input string tag, input int mode, input int n, input int rmode, input bit poke);
    logic [95:0] exp_q[$];
    logic [95:0] cur;
    logic [31:0] s, chk_exp;
    int k, cyc, dones, low_cnt;
    bit first;
    exp_q = {};
    s = SEED;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_vec(mode, i, s));
      s = lfsr_adv(s);
    end
    obs_q = {};
    chk_exp = '0;
    @(negedge clk);
    start_i = 1'b1; mode_i = 2'(mode); num_vec_i = 16'(n); bus.ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0; mode_i = 2'($urandom_range(0, 3)); num_vec_i = 16'($urandom_range(1, 50));
    chk({tag, "_t1_valid"}, 96'(bus.valid_o), 96'd0);
    if (n == 0) begin
      chk({tag, "_t1_done"}, 96'(done_o), 96'd1);
      @(negedge clk);
      chk({tag, "_t2_done"}, 96'(done_o), 96'd0);
      chk({tag, "_t2_valid"}, 96'(bus.valid_o), 96'd0);
      return;
    end
    chk({tag, "_t1_busy"}, 96'(busy_o), 96'd1);
    k = 0; cyc = 0; dones = 0; low_cnt = 0; first = 1'b1;
    while (dones == 0 && cyc < 4 * n + 50) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0;
      if (first) begin
        chk({tag, "_latency_valid"}, 96'(bus.valid_o), 96'd1);
        first = 1'b0;
      end
      if (done_o) begin
        dones++;
        bus.ready_i = 1'b0;
        chk({tag, "_done_count"}, 96'(k), 96'(n));
        chk({tag, "_done_valid"}, 96'(bus.valid_o), 96'd0);
      end else if (k >= n) begin
        chk({tag, "_done_late"}, 96'(done_o), 96'd1);
      end else if (!bus.valid_o) begin
        chk({tag, "_valid_gap"}, 96'(bus.valid_o), 96'd1);
      end else begin
        cur = {bus.A_o, bus.B_o, bus.C_o};
        chk({tag, "_vec"}, cur, exp_q[k]);
        chk({tag, "_idx"}, 96'(bus.vec_idx_o), 96'(k));
        if (mode == 2) begin
          for (int j = 0; j < 3; j++) begin
            int e;
            e = int'(cur[j*32+23 +: 8]);
            chk({tag, "_exp_range"}, 96'(e >= 1 && e <= 254), 96'd1);
          end
        end
        if (poke && k == 1) begin
          start_i = 1'b1; num_vec_i = 16'd3; mode_i = 2'd3;
        end
        case (rmode)
          0:       bus.ready_i = 1'b1;
          1:       bus.ready_i = 1'($urandom_range(0, 1));
          default: begin
            bus.ready_i = (low_cnt >= 4);
            if (low_cnt < 4) low_cnt++;
          end
        endcase
        if (bus.ready_i) begin
          obs_q.push_back(cur);
          chk_exp = chk_exp ^ cur[95:64] ^ cur[63:32] ^ cur[31:0];
          k++;
        end
      end
    end
    chk({tag, "_done_seen"}, 96'(dones), 96'd1);
    if (rmode == 2) chk({tag, "_held_cycles"}, 96'(low_cnt), 96'd4);
`ifdef MAC_STIM_CHECKSUM_EN
    chk({tag, "_chksum"}, 96'(chksum_o), 96'(chk_exp));
`endif
    @(negedge clk);
    chk({tag, "_post_done"}, 96'(done_o), 96'd0);
    chk({tag, "_post_busy"}, 96'(busy_o), 96'd0);
  endtask

  initial begin
    bus.ready_i = 1'b0;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 96'(bus.valid_o), 96'd0);
    chk("rst_busy", 96'(busy_o), 96'd0);
    chk("rst_done", 96'(done_o), 96'd0);
    chk("rst_abc", {bus.A_o, bus.B_o, bus.C_o}, 96'd0);
    chk("rst_idx", 96'(bus.vec_idx_o), 96'd0);
    rst = 1'b0;

    run_vec("dir5", 0, 5, 0, 1'b0);
    run_vec("dir2_hold", 0, 2, 2, 1'b0);
    run_vec("spec6", 3, 6, 0, 1'b0);
    run_vec("n0", 1, 0, 0, 1'b0);
    run_vec("poke", 1, 8, 1, 1'b1);

    // async reset while vector 3 of 10 is on the bus
    @(negedge clk);
    start_i = 1'b1; mode_i = 2'd1; num_vec_i = 16'd10; bus.ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 20 && !(bus.valid_o && bus.vec_idx_o == 16'd3); c++) @(negedge clk);
    chk("abort_at_idx3", 96'(bus.vec_idx_o), 96'd3);
    bus.ready_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 96'(bus.valid_o), 96'd0);
    chk("abort_busy", 96'(busy_o), 96'd0);
    chk("abort_a", 96'(bus.A_o), 96'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_done", 96'(done_o), 96'd0);
    end
    run_vec("fresh", 1, 10, 0, 1'b0);

    run_vec("norm_a", 2, 1000, 1, 1'b0);
    run1_q = obs_q;
    run_vec("norm_b", 2, 1000, 1, 1'b0);
    chk("repeat_len", 96'(obs_q.size()), 96'(run1_q.size()));
    for (int i = 0; i < obs_q.size() && i < run1_q.size(); i++)
      chk("repeat_vec", obs_q[i], run1_q[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
